// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder: receive side of a four-digit multiplexed seven-segment
// display. It synchronises the scanned segment and digit-enable lines and waits
// for each scan slot to settle. It then decodes the slot's pattern back to a hex
// nibble and reassembles the digits into bcd1..bcd4, with frame and staleness
// tracking.
// Optional build macro SEVSEG_DEC_ERRCNT_EN adds err_cnt, a saturating count of
// qualified captures whose pattern did not decode.
module seven_segment_decoder #(
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk_50mhz,
    input  logic       reset,
    input  logic       segA,
    input  logic       segB,
    input  logic       segC,
    input  logic       segD,
    input  logic       segE,
    input  logic       segF,
    input  logic       segG,
    input  logic       dsen1,
    input  logic       dsen2,
    input  logic       dsen3,
    input  logic       dsen4,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] bcd4,
    output logic [3:0] digit_valid,
    output logic       frame_strobe,
    output logic       frame_valid,
    output logic       stale
`ifdef SEVSEG_DEC_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int SW = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    // Vector layout: [10:4] = {A,B,C,D,E,F,G}, [3:0] = {dsen4,dsen3,dsen2,dsen1}
    logic [10:0]   raw;
    logic [10:0]   sync0;
    logic [10:0]   sync1;
    logic [10:0]   vec_q;
    logic [SW-1:0] stable_cnt;
    logic          cap_done;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    seen;
    logic [3:0]    sel;
    logic [3:0]    seen_next;
    logic          changed;
    logic          settled;
    logic          capture;
    logic          cap_ok;
    logic [4:0]    dec;
    logic          legal;
    logic [3:0]    nib;

    // {legal, nibble} for a {A..G} pattern; anything outside the table is illegal
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b1111110: r = 5'h10;
            7'b0110000: r = 5'h11;
            7'b1101101: r = 5'h12;
            7'b1111001: r = 5'h13;
            7'b0110011: r = 5'h14;
            7'b1011011: r = 5'h15;
            7'b1011111: r = 5'h16;
            7'b1110000: r = 5'h17;
            7'b1111111: r = 5'h18;
            7'b1111011: r = 5'h19;
            7'b1110111: r = 5'h1A;
            7'b0011111: r = 5'h1B;
            7'b1001110: r = 5'h1C;
            7'b0111101: r = 5'h1D;
            7'b1001111: r = 5'h1E;
            7'b1000111: r = 5'h1F;
            default:    r = 5'h00;
        endcase
        return r;
    endfunction

    // Map undriven or unknown pins to 0 so a floating line reads as unlit / enabled-low
    always_comb begin
        raw = {segA === 1'b1, segB === 1'b1, segC === 1'b1, segD === 1'b1,
               segE === 1'b1, segF === 1'b1, segG === 1'b1,
               dsen4 === 1'b1, dsen3 === 1'b1, dsen2 === 1'b1, dsen1 === 1'b1};
    end

    // Capture strobes and decode of the settled vector
    always_comb begin
        changed   = (sync1 != vec_q);
        settled   = (stable_cnt == SW'(SETTLE_CYCLES - 1));
        capture   = settled && !cap_done;
        sel       = ~vec_q[3:0];
        cap_ok    = capture && $onehot(sel);
        dec       = decode(vec_q[10:4]);
        legal     = dec[4];
        nib       = dec[3:0];
        seen_next = seen | sel;
    end

    // Two-flop synchroniser plus the previous-cycle copy used for change detection
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            sync0 <= '0;
            sync1 <= '0;
            vec_q <= '0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            vec_q <= sync1;
        end
    end

    // Stability counter and one-capture-per-slot flag
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            stable_cnt <= '0;
            cap_done   <= 1'b0;
        end else if (changed) begin
            stable_cnt <= '0;
            cap_done   <= 1'b0;
        end else begin
            if (!settled) stable_cnt <= stable_cnt + 1'b1;
            if (capture)  cap_done   <= 1'b1;
        end
    end

    // Per-digit nibble and legality; an illegal pattern keeps the old nibble
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            bcd1        <= '0;
            bcd2        <= '0;
            bcd3        <= '0;
            bcd4        <= '0;
            digit_valid <= '0;
        end else if (cap_ok) begin
            if (legal) begin
                case (sel)
                    4'b0001: bcd1 <= nib;
                    4'b0010: bcd2 <= nib;
                    4'b0100: bcd3 <= nib;
                    4'b1000: bcd4 <= nib;
                    default: ;
                endcase
            end
            digit_valid <= (digit_valid & ~sel) | (legal ? sel : 4'b0000);
        end
    end

    // Frame completion, idle timeout and staleness
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            seen         <= '0;
            idle_cnt     <= '0;
            frame_strobe <= 1'b0;
            frame_valid  <= 1'b0;
            stale        <= 1'b0;
        end else begin
            frame_strobe <= 1'b0;
            if (cap_ok) begin
                idle_cnt <= '0;
                if (seen_next == 4'hF) begin
                    frame_strobe <= 1'b1;
                    frame_valid  <= 1'b1;
                    stale        <= 1'b0;
                    seen         <= '0;
                end else begin
                    seen <= seen_next;
                end
            end else begin
                if (idle_cnt != IW'(TIMEOUT_CYCLES)) idle_cnt <= idle_cnt + 1'b1;
                // Fires on the edge the count reaches TIMEOUT_CYCLES, and holds there
                if (idle_cnt >= IW'(TIMEOUT_CYCLES - 1)) begin
                    stale       <= 1'b1;
                    frame_valid <= 1'b0;
                end
            end
        end
    end

`ifdef SEVSEG_DEC_ERRCNT_EN
    // Saturating count of qualified captures with undecodable patterns
    always_ff @(posedge clk_50mhz or negedge reset) begin
        if (!reset) begin
            err_cnt <= '0;
        end else if (cap_ok && !legal && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Directed bench for seven_segment_decoder with a frame scoreboard: the expected
// digits, validity mask and strobe cycle are queued when the last slot of a
// frame is driven, and popped when frame_strobe is seen.
module tb_seven_segment_decoder;

    localparam int S = 4;
    localparam int T = 50;

    logic clk = 1'b0;
    logic rst_n;
    logic sa, sb_, sc, sd, se, sf, sg;
    logic d1, d2, d3, d4;
    logic [3:0] bcd1, bcd2, bcd3, bcd4, digit_valid;
    logic frame_strobe, frame_valid, stale;
`ifdef SEVSEG_DEC_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    seven_segment_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk_50mhz(clk), .reset(rst_n),
        .segA(sa), .segB(sb_), .segC(sc), .segD(sd), .segE(se), .segF(sf), .segG(sg),
        .dsen1(d1), .dsen2(d2), .dsen3(d3), .dsen4(d4),
        .bcd1(bcd1), .bcd2(bcd2), .bcd3(bcd3), .bcd4(bcd4),
        .digit_valid(digit_valid), .frame_strobe(frame_strobe),
        .frame_valid(frame_valid), .stale(stale)
`ifdef SEVSEG_DEC_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  val;
        int          at;
    } exp_t;

    exp_t sbq[$];
    int tests = 0;
    int fails = 0;
    int last_strobe_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'b1111110;  4'h1: p = 7'b0110000;
            4'h2: p = 7'b1101101;  4'h3: p = 7'b1111001;
            4'h4: p = 7'b0110011;  4'h5: p = 7'b1011011;
            4'h6: p = 7'b1011111;  4'h7: p = 7'b1110000;
            4'h8: p = 7'b1111111;  4'h9: p = 7'b1111011;
            4'hA: p = 7'b1110111;  4'hB: p = 7'b0011111;
            4'hC: p = 7'b1001110;  4'hD: p = 7'b0111101;
            4'hE: p = 7'b1001111;  default: p = 7'b1000111;
        endcase
        return p;
    endfunction

    task automatic set_pins(input logic [3:0] en, input logic [6:0] pat);
        {sa, sb_, sc, sd, se, sf, sg} = pat;
        {d4, d3, d2, d1} = en;
    endtask

    task automatic slot(input int d, input logic [6:0] pat, input int hold);
        logic [3:0] en;
        en = 4'hF;
        en[d-1] = 1'b0;
        set_pins(en, pat);
        repeat (hold) @(negedge clk);
    endtask

    // Queue a frame expected to complete from the slot driven right now
    task automatic push(input logic [15:0] b, input logic [3:0] v);
        exp_t e;
        e.bcd = b;
        e.val = v;
        e.at  = cyc + S + 3;
        sbq.push_back(e);
    endtask

    task automatic check_bcd(input string tag, input logic [15:0] b);
        check(tag, {bcd4, bcd3, bcd2, bcd1}, b);
    endtask

    // Scoreboard consumer: every strobe must match a queued frame
    always @(negedge clk) begin
        if (rst_n === 1'b1 && frame_strobe === 1'b1) begin
            last_strobe_cyc = cyc;
            if (sbq.size() == 0) begin
                check("unexpected_strobe", frame_strobe, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("frame_bcd", {bcd4, bcd3, bcd2, bcd1}, e.bcd);
                check("frame_mask", digit_valid, e.val);
                check("strobe_cycle", cyc, e.at);
                check("strobe_frame_valid", frame_valid, 1);
                check("strobe_stale", stale, 0);
            end
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        set_pins(4'hF, 7'b0);
        repeat (3) @(negedge clk);
        check_bcd("rst_bcd", 16'h0000);
        check("rst_valid", digit_valid, 0);
        check("rst_strobe", frame_strobe, 0);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_stale", stale, 0);
`ifdef SEVSEG_DEC_ERRCNT_EN
        check("rst_err", err_cnt, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Basic frame, dsen4 low down to dsen1 low
        slot(4, seg_of(4'h4), 20);
        slot(3, seg_of(4'h3), 20);
        slot(2, seg_of(4'h2), 20);
        push(16'h4321, 4'hF);
        slot(1, seg_of(4'h1), 20);
        check("t1_drained", sbq.size(), 0);
        check_bcd("t1_bcd", 16'h4321);

        // segA toggling every 3 clocks never settles
        for (int i = 0; i < 12; i++) begin
            set_pins(4'b1110, (i % 2 == 1) ? 7'b0111111 : 7'b1111111);
            repeat (3) @(negedge clk);
        end
        set_pins(4'hF, 7'b0);
        repeat (20) @(negedge clk);
        check_bcd("glitch_bcd", 16'h4321);
        check("glitch_valid", digit_valid, 4'hF);

        // Illegal pattern after a legal 7 on digit 2
        slot(2, seg_of(4'h7), 20);
        check_bcd("legal7_bcd", 16'h4371);
        check("legal7_valid", digit_valid, 4'hF);
        slot(2, 7'b0000001, 20);
        check_bcd("illegal_bcd", 16'h4371);
        check("illegal_valid", digit_valid, 4'b1101);
`ifdef SEVSEG_DEC_ERRCNT_EN
        check("illegal_err", err_cnt, 1);
`endif

        // Blanking then two enables low: nothing captured
        set_pins(4'hF, seg_of(4'h8));
        repeat (100) @(negedge clk);
        set_pins(4'b1100, seg_of(4'h8));
        repeat (100) @(negedge clk);
        check_bcd("blank_bcd", 16'h4371);
        check("blank_valid", digit_valid, 4'b1101);
        check("blank_stale", stale, 1);
        check("blank_frame_valid", frame_valid, 0);

        // Digit 2 is still in the seen mask, so 4,3,1 complete the frame
        slot(4, seg_of(4'h9), 20);
        slot(3, seg_of(4'hA), 20);
        push(16'h9A7B, 4'b1101);
        slot(1, seg_of(4'hB), 20);
        check("mask_drained", sbq.size(), 0);

        // Frozen inputs: stale exactly T clocks after the strobe
        n = 0;
        while (stale !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("stale_delay", cyc - last_strobe_cyc, T);
        check("stale_frame_valid", frame_valid, 0);
        check_bcd("stale_bcd", 16'h9A7B);
        check("stale_valid", digit_valid, 4'b1101);

        slot(4, seg_of(4'hC), 20);
        slot(3, seg_of(4'hD), 20);
        slot(2, seg_of(4'hE), 20);
        push(16'hCDEF, 4'hF);
        slot(1, seg_of(4'hF), 20);
        check("recover_stale", stale, 0);
        check("recover_frame_valid", frame_valid, 1);

        // Reset mid-slot after two digits captured
        slot(4, seg_of(4'h0), 20);
        slot(3, seg_of(4'h5), 20);
        slot(2, seg_of(4'h6), 3);
        rst_n = 1'b0;
        #1;
        check_bcd("midrst_bcd", 16'h0000);
        check("midrst_valid", digit_valid, 0);
        check("midrst_strobe", frame_strobe, 0);
        check("midrst_frame_valid", frame_valid, 0);
        check("midrst_stale", stale, 0);
`ifdef SEVSEG_DEC_ERRCNT_EN
        check("midrst_err", err_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        slot(1, seg_of(4'h8), 20);
        check_bcd("postrst_bcd", 16'h0068);
        check("postrst_valid", digit_valid, 4'b0011);
        check("postrst_frame_valid", frame_valid, 0);
        slot(4, seg_of(4'h2), 20);
        push(16'h2968, 4'hF);
        slot(3, seg_of(4'h9), 20);
        check("final_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_segment_decoder.md
Name: seven_segment_decoder

Overview:
- Receive-side counterpart of the four-digit multiplexed seven-segment display interface.
- Samples the scanned segment lines (segA..segG) and the active-low digit enables (dsen1..dsen4) and waits for each scan slot to settle.
- Decodes each slot's segment pattern back to a hex nibble and reassembles the four digits into bcd1..bcd4.
- Used for loopback self-test of the display path and for snooping an external multiplexed display.

Parameters:
- SETTLE_CYCLES, 64: consecutive clocks the synchronised 11-bit input vector must be unchanged before a slot is captured; legal range 2..65535.
- TIMEOUT_CYCLES, 200000: clocks without any capture before the decoded data is declared stale; counter width derived by $clog2.

Ports:
- clk_50mhz  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- segA..segG  in  1 each  segment lines, 1 = lit; any non-1 level is treated as unlit
- dsen1..dsen4  in  1 each  digit enables, active low; dsenN low selects digit N (dsen1 = rightmost/LSB digit)
- bcd1..bcd4  out  4 each  last decoded nibble per digit
- digit_valid  out  4  bit N-1 set when digit N's last captured pattern was legal
- frame_strobe  out  1  one-cycle pulse when all four digits have been captured since the previous pulse
- frame_valid  out  1  at least one full frame has been received and data is not stale
- stale  out  1  no capture for TIMEOUT_CYCLES

Behaviour:
- Reset: asserted (reset = 0) asynchronously sets
  - bcd1..bcd4 = 0, digit_valid = 0, frame_strobe = 0, frame_valid = 0, stale = 0;
  - all counters, the seen mask and the capture-done flag to 0.
- Synchronisation: two-flop synchroniser on all 11 inputs. Input z or x is mapped to 0 before the first flop.
- Stability filter:
  - stable_cnt resets to 0 on any change of the synchronised vector; otherwise it increments, saturating at SETTLE_CYCLES-1.
  - A capture fires on the first cycle stable_cnt == SETTLE_CYCLES-1 with the capture-done flag clear. The capture sets the flag.
  - The flag clears on any vector change, so there is exactly one capture per settled slot.
- Capture qualification: only when exactly one of dsen1..dsen4 is 0.
  - Enables 1111 (blanking) or more than one enable low: no capture, and the capture-done flag is still set.
- Decode table, {A,B,C,D,E,F,G} -> nibble:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 1110111->A, 0011111->B
  - 1001110->C, 0111101->D, 1001111->E, 1000111->F
- Capture result:
  - Legal pattern: bcdN takes the nibble and digit_valid[N-1] = 1.
  - Illegal pattern: bcdN holds its previous value and digit_valid[N-1] = 0.
  - Outputs update on the clock edge after the capture cycle.
  - Latency from a stable pin change to bcdN: 2 + SETTLE_CYCLES + 1 clocks.
- Frame tracking:
  - A 4-bit seen mask sets bit N-1 on every qualified capture, legal or illegal.
  - When the mask reaches 1111, on the same edge as the bcd update: frame_strobe = 1 for one cycle, frame_valid = 1, stale = 0, mask cleared.
  - Recapturing an already-seen digit before the mask is complete is allowed: bcdN is overwritten and the mask bit stays set.
- Timeout:
  - idle_cnt resets on every qualified capture and otherwise increments, saturating.
  - Reaching TIMEOUT_CYCLES sets stale = 1 and frame_valid = 0. bcdN and digit_valid are retained.
  - stale clears only on the next frame_strobe.
- Reset mid-slot: all state clears immediately; the first capture after release needs a full settle period.

Optional Feature:
- Macro: SEVSEG_DEC_ERRCNT_EN.
- Defined:
  - Adds output port err_cnt [7:0]: a saturating count of qualified captures with illegal patterns.
  - Resets to 0 and sticks at 255.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- SETTLE_CYCLES=4; drive dsen=1110/0111 sequence (dsen4 low .. dsen1 low) with patterns for 4,3,2,1, each held 20 clocks -> bcd4..bcd1 = 4,3,2,1; digit_valid = 1111; exactly one frame_strobe, 7 clocks after the last slot's pins change.
- Glitch: toggle segA every 3 clocks with SETTLE_CYCLES=4 -> no capture; bcd unchanged; stable_cnt never reaches 3.
- Illegal pattern 0000001 on digit 2 after a prior legal 7 -> bcd2 stays 7; digit_valid[1] = 0; err_cnt increments to 1 when SEVSEG_DEC_ERRCNT_EN is defined.
- Blanking (dsen = 1111) and two-low (dsen = 1100) held 100 clocks -> no capture; seen mask unchanged; no frame_strobe.
- TIMEOUT_CYCLES=50: one full frame, then inputs frozen -> stale = 1 and frame_valid = 0 at 50 clocks after the last capture; the next full frame clears stale and sets frame_valid.
- Assert reset for 1 cycle mid-slot after 2 of 4 digits are captured -> all outputs 0 asynchronously; a full new frame is needed for frame_strobe.
